// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer: ALU select codes, sequencer op codes and FSM states.
package alu_seq_pkg;

  localparam logic [2:0] SelAdd  = 3'b000;
  localparam logic [2:0] SelAnd  = 3'b001;
  localparam logic [2:0] SelOr   = 3'b010;
  localparam logic [2:0] SelXor  = 3'b011;
  localparam logic [2:0] SelNot  = 3'b100;
  localparam logic [2:0] SelShl1 = 3'b101;
  localparam logic [2:0] SelShr1 = 3'b110;
  localparam logic [2:0] SelZero = 3'b111;

  localparam logic [1:0] OpSlln = 2'b00;
  localparam logic [1:0] OpSrln = 2'b01;
  localparam logic [1:0] OpMul  = 2'b10;
  localparam logic [1:0] OpRsvd = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StMadd,
    StMshl,
    StDone
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake plus the ALU drive/return bus of the op sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             err;
  logic             alu_own;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;

  // Master is the requester/ALU side; slave is the sequencer itself.
  modport master (
    output start, op, opa, opb, alu_y, alu_zero,
    input  busy, done, result, zero_flag, err, alu_own, alu_sel, alu_a, alu_b
  );

  modport slave (
    input  start, op, opa, opb, alu_y, alu_zero,
    output busy, done, result, zero_flag, err, alu_own, alu_sel, alu_a, alu_b
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multicycle sequencer building shift-by-N and shift-add multiply from repeated passes of a
// shared shift-by-1/add ALU.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input logic                clk,
  input logic                rst_n,
  alu_op_sequencer_if.slave  bus
);

  seq_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [SHW-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic             r_err, w_err_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_own;
  logic [2:0]       w_sel;
  logic [WIDTH-1:0] w_a, w_b;

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_err_nxt    = r_err;
    w_own        = 1'b0;
    w_sel        = SelZero;
    w_a          = '0;
    w_b          = '0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_err_nxt = 1'b0;
          w_op_nxt  = bus.op;
          unique case (bus.op)
            OpSlln, OpSrln: begin
              w_acc_nxt   = bus.opa;
              w_cnt_nxt   = bus.opb[SHW-1:0];
              w_state_nxt = (bus.opb[SHW-1:0] == '0) ? StDone : StShift;
            end
            OpMul: begin
              w_acc_nxt    = '0;
              w_mcand_nxt  = bus.opa;
              w_mplier_nxt = bus.opb;
              w_state_nxt  = (bus.opb == '0) ? StDone : StMadd;
            end
            default: begin
              w_err_nxt   = 1'b1;
              w_acc_nxt   = '0;
              w_state_nxt = StDone;
            end
          endcase
        end
      end
      StShift: begin
        w_own     = 1'b1;
        w_sel     = (r_op == OpSrln) ? SelShr1 : SelShl1;
        w_a       = r_acc;
        w_acc_nxt = bus.alu_y;
        w_cnt_nxt = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) w_state_nxt = StDone;
      end
      StMadd: begin
        w_own = 1'b1;
        w_sel = SelAdd;
        w_a   = r_acc;
        w_b   = r_mcand;
        if (r_mplier[0]) w_acc_nxt = bus.alu_y;
        w_state_nxt = StMshl;
      end
      StMshl: begin
        w_own        = 1'b1;
        w_sel        = SelShl1;
        w_a          = r_mcand;
        w_mcand_nxt  = bus.alu_y;
        w_mplier_nxt = r_mplier >> 1;
        // Stop once no multiplier bits remain above the one just consumed.
        w_state_nxt  = (r_mplier[WIDTH-1:1] == '0) ? StDone : StMadd;
      end
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_op     <= OpSlln;
      r_err    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_err    <= w_err_nxt;
      // Capture on entry to DONE so result is valid during the done pulse.
      if (w_state_nxt == StDone && r_state != StDone) begin
        r_result <= w_acc_nxt;
        r_zero   <= (w_acc_nxt == '0);
      end
    end
  end

  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = (r_state == StDone);
  assign bus.result    = r_result;
  assign bus.zero_flag = r_zero;
  assign bus.err       = r_err;
  assign bus.alu_own   = w_own;
  assign bus.alu_sel   = w_sel;
  assign bus.alu_a     = w_a;
  assign bus.alu_b     = w_b;

endmodule
